polar_fg_sched: RTL and testbench
=================================

Name: polar_fg_sched

Overview:
- Sequencer for polar-decoder node processing on 8-bit signed LLRs.
- Buffers one node vector of 2*M LLRs, then on command streams M results of the f (min-sum), g (saturating add/sub) or R (hard decision) kernel, one per cycle.
- Sits beside the integer ALU in the execute stage so vector polar work is not issued one scalar op at a time.
- Arithmetic matches the scalar PL_F / PL_G / PL_R semantics exactly.

Parameters:
- M, 8: half node length; results per command; must be a power of 2, >= 2.
- QTF_SIZE, 8: LLR width in bits, two's complement.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- llr_valid_i  in  1  LLR load word valid.
- llr_ready_o  out  1  LLR load word accepted.
- llr_data_i  in  QTF_SIZE  LLR word, index order 0..2M-1.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted.
- cmd_op_i  in  2  0=F, 1=G, 2=R, 3=reserved (treated as R).
- cmd_bits_i  in  M  G: partial sums u[i]; R: frozen mask.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_data_o  out  QTF_SIZE  result word.
- res_last_o  out  1  marks result index M-1.
- busy_o  out  1  high in LOAD or RUN.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, full=0, load index=0, result index=0, res_valid_o=0, res_data_o=0, res_last_o=0, busy_o=0.
- States: IDLE, LOAD, RUN.
- Definitions: a[i] = buffer[i]; b[i] = buffer[i+M].
- Load path:
  - llr_ready_o = (IDLE or LOAD) and not (IDLE and full and cmd_valid_i).
  - On a load handshake: store the word at the load index and increment it.
  - A load handshake in IDLE clears full, writes index 0 and moves to LOAD.
  - -128 is clamped to -127 on write (so magnitude fits in QTF_SIZE-1 bits).
  - At index 2M-1: set full, clear the load index, return to IDLE.
- Command path:
  - cmd_ready_o = IDLE and full.
  - When a command and a load are both valid in IDLE with full=1, the command wins.
  - On a command handshake: latch op and bits, clear the result index, move to RUN.
  - full stays set, so the same vector can be reused (F then G without reload).
- Kernels (per index i):
  - F: sign(a) xor sign(b), magnitude min(|a|,|b|).
  - G: u[i]=0 gives a+b, u[i]=1 gives b-a. Computed at QTF_SIZE+1 bits, then saturated to [-127,+127] (0x7F / 0x81).
  - R: output 0 if the frozen bit is set, else 1 when a[i]<0, else 0. Zero-extended to QTF_SIZE.
- Output stage (single register):
  - First result is valid the cycle after the command handshake (latency 1).
  - The register loads the next index whenever it is empty or a handshake occurs, giving 1 result/cycle with res_ready_i held high.
  - res_data_o, res_valid_o and res_last_o are stable while res_valid_o=1 and res_ready_i=0.
- Completion: after the handshake with res_last_o=1, res_valid_o drops and the state returns to IDLE in that same edge. A new command can be accepted the next cycle.
- Reset mid-LOAD or mid-RUN aborts immediately. full=0, so a full reload is required.

Optional Feature:
- Macro: POLAR_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt_o, 16 bits, reset 0.
  - Increments on each accepted G result that saturated; saturates at 0xFFFF.
  - Cleared when a command is accepted.
- When undefined: port and counter are absent, and no other behaviour changes.

Decomposition:
- Shared polar package:
  - pl_cmd_e enum (PL_CMD_F, PL_CMD_G, PL_CMD_R).
  - QTF_SIZE default, LLR_MAX=127, LLR_MIN=-127 constants.
  - pure functions pl_f, pl_g_sat, pl_r (reusable by the ALU).
- One sub-module, polar_fg_kernel: combinational; inputs a, b, bit, op; outputs result and sat flag.
- The scheduler holds the buffer, FSM, indices and output register.

Test Plan:
- Load 0..15 (M=8), then F with bits=0 → results min(i, i+8) = 0..7, res_last_o only on the 8th, one per cycle with ready high.
- Load a=+100, b=+100 everywhere; G with bits=0 → all 0x7F. Same load, bits=0xFF → all 0x00. Load a=+100, b=-100, bits=0xFF → all 0x81. With POLAR_SAT_CNT_EN, sat_cnt_o is 8 after each saturating run.
- Load a=-5, b=+3; F → 0xFD (-3). Load a=-128, b=-1; F → 0x01 (clamp check).
- Load a[i]=-1; R with frozen mask 0x0F → results 0,0,0,0,1,1,1,1.
- Backpressure: toggle res_ready_i 1/0 every cycle during F → data held stable, 8 results in 16 cycles, no loss or duplication. Full vector plus command pending in IDLE with both valid → command accepted, llr_ready_o=0.
- Assert rst_ni mid-RUN at result 3 → outputs zero, cmd_ready_o=0 until 16 new words are loaded.

Source files
------------

// File: rtl/polar_fg_sched_pkg.sv
// polar_fg_sched_pkg: shared polar-decoder types, constants and scalar PL_F/PL_G/PL_R kernels.
// Revision: 1.0
`default_nettype none

package polar_fg_sched_pkg;

  localparam int PL_QTF_SIZE = 8;
  localparam int LLR_MAX     = 127;
  localparam int LLR_MIN     = -127;

  typedef enum logic [1:0] {
    PL_CMD_F = 2'd0,
    PL_CMD_G = 2'd1,
    PL_CMD_R = 2'd2
  } pl_cmd_e;

  typedef logic signed [PL_QTF_SIZE-1:0] llr_t;

  function automatic llr_t pl_f(input llr_t a, input llr_t b);
    llr_t ma, mb, m;
    ma = a[PL_QTF_SIZE-1] ? -a : a;
    mb = b[PL_QTF_SIZE-1] ? -b : b;
    m  = (ma < mb) ? ma : mb;
    return (a[PL_QTF_SIZE-1] ^ b[PL_QTF_SIZE-1]) ? -m : m;
  endfunction

  function automatic llr_t pl_g_sat(input llr_t a, input llr_t b, input logic u);
    logic signed [PL_QTF_SIZE:0] s;
    s = u ? ({b[PL_QTF_SIZE-1], b} - {a[PL_QTF_SIZE-1], a})
          : ({b[PL_QTF_SIZE-1], b} + {a[PL_QTF_SIZE-1], a});
    if (s > (PL_QTF_SIZE+1)'(LLR_MAX)) return llr_t'(LLR_MAX);
    if (s < (PL_QTF_SIZE+1)'(LLR_MIN)) return llr_t'(LLR_MIN);
    return s[PL_QTF_SIZE-1:0];
  endfunction

  function automatic llr_t pl_r(input llr_t a, input logic frozen);
    return {{(PL_QTF_SIZE-1){1'b0}}, ~frozen & a[PL_QTF_SIZE-1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/polar_fg_sched_kernel.sv
// polar_fg_kernel: combinational F / G / R node kernel for one LLR pair, width-generic.
// Revision: 1.0
`default_nettype none

module polar_fg_kernel
  import polar_fg_sched_pkg::*;
#(
  parameter int QTF_SIZE = PL_QTF_SIZE
) (
  input  logic signed [QTF_SIZE-1:0] a,
  input  logic signed [QTF_SIZE-1:0] b,
  input  logic                       u_bit,
  input  logic [1:0]                 op,
  output logic signed [QTF_SIZE-1:0] result,
  output logic                       sat
);

  localparam logic signed [QTF_SIZE:0] S_MAX = (QTF_SIZE+1)'((1 << (QTF_SIZE-1)) - 1);
  localparam logic signed [QTF_SIZE:0] S_MIN = -S_MAX;

  logic [QTF_SIZE-1:0]        mag_a, mag_b, mag;
  logic signed [QTF_SIZE-1:0] f_res, g_res, r_res;
  logic signed [QTF_SIZE:0]   sum;
  logic                       g_sat;

  always_comb begin
    // Inputs never hold the most negative code, so negation cannot overflow.
    mag_a = a[QTF_SIZE-1] ? (~a + 1'b1) : a;
    mag_b = b[QTF_SIZE-1] ? (~b + 1'b1) : b;
    mag   = (mag_a < mag_b) ? mag_a : mag_b;
    f_res = (a[QTF_SIZE-1] ^ b[QTF_SIZE-1]) ? (~mag + 1'b1) : mag;

    sum   = u_bit ? ({b[QTF_SIZE-1], b} - {a[QTF_SIZE-1], a})
                  : ({b[QTF_SIZE-1], b} + {a[QTF_SIZE-1], a});
    g_sat = 1'b1;
    if (sum > S_MAX)      g_res = S_MAX[QTF_SIZE-1:0];
    else if (sum < S_MIN) g_res = S_MIN[QTF_SIZE-1:0];
    else begin
      g_res = sum[QTF_SIZE-1:0];
      g_sat = 1'b0;
    end

    r_res = {{(QTF_SIZE-1){1'b0}}, ~u_bit & a[QTF_SIZE-1]};

    result = r_res;
    sat    = 1'b0;
    if (op == PL_CMD_F) result = f_res;
    else if (op == PL_CMD_G) begin
      result = g_res;
      sat    = g_sat;
    end
  end

endmodule

`default_nettype wire

// File: rtl/polar_fg_sched.sv
// polar_fg_sched: buffers 2*M LLRs and streams M F/G/R results per command (optional POLAR_SAT_CNT_EN).
// Revision: 1.0
`default_nettype none

module polar_fg_sched
  import polar_fg_sched_pkg::*;
#(
  parameter int M        = 8,
  parameter int QTF_SIZE = PL_QTF_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                llr_valid_i,
  output logic                llr_ready_o,
  input  logic [QTF_SIZE-1:0] llr_data_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [M-1:0]        cmd_bits_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [QTF_SIZE-1:0] res_data_o,
  output logic                res_last_o,
  output logic                busy_o
`ifdef POLAR_SAT_CNT_EN
  ,
  output logic [15:0]         sat_cnt_o
`endif
);

  localparam int LW = $clog2(2*M);
  localparam int RW = $clog2(M);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [QTF_SIZE-1:0] LLR_NEG  = {1'b1, {(QTF_SIZE-1){1'b0}}};
  localparam logic [QTF_SIZE-1:0] LLR_NEG1 = {1'b1, {(QTF_SIZE-2){1'b0}}, 1'b1};

  logic [1:0]                 state;
  logic                       full;
  logic [LW-1:0]              load_idx;
  logic [RW-1:0]              res_idx;
  logic                       issued_all;
  logic [1:0]                 op;
  logic [M-1:0]               bits;
  logic signed [QTF_SIZE-1:0] buffer [2*M];

  logic signed [QTF_SIZE-1:0] llr_in, k_res;
  logic                       k_sat;
  logic                       load_fire, cmd_fire, res_fire, issue;

  assign cmd_ready_o = (state == ST_IDLE) && full;
  assign llr_ready_o = ((state == ST_IDLE) || (state == ST_LOAD)) &&
                       !((state == ST_IDLE) && full && cmd_valid_i);
  assign load_fire   = llr_valid_i && llr_ready_o;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign res_fire    = res_valid_o && res_ready_i;
  assign issue       = (state == ST_RUN) && !issued_all && (!res_valid_o || res_ready_i);
  assign busy_o      = (state != ST_IDLE);
  assign llr_in      = (llr_data_i == LLR_NEG) ? LLR_NEG1 : llr_data_i;

  // Load index is always zero in IDLE, so the first word lands at index 0.
  always_ff @(posedge clk_i) begin
    if (load_fire) buffer[load_idx] <= llr_in;
  end

  polar_fg_kernel #(.QTF_SIZE(QTF_SIZE)) u_kernel (
    .a      (buffer[{1'b0, res_idx}]),
    .b      (buffer[{1'b1, res_idx}]),
    .u_bit  (bits[res_idx]),
    .op     (op),
    .result (k_res),
    .sat    (k_sat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      full        <= 1'b0;
      load_idx    <= '0;
      res_idx     <= '0;
      issued_all  <= 1'b0;
      op          <= 2'd0;
      bits        <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_last_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            op         <= cmd_op_i;
            bits       <= cmd_bits_i;
            res_idx    <= '0;
            issued_all <= 1'b0;
            state      <= ST_RUN;
          end else if (load_fire) begin
            full     <= 1'b0;
            load_idx <= load_idx + 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            if (load_idx == LW'(2*M-1)) begin
              full     <= 1'b1;
              load_idx <= '0;
              state    <= ST_IDLE;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            res_valid_o <= 1'b1;
            res_data_o  <= k_res;
            res_last_o  <= (res_idx == RW'(M-1));
            res_idx     <= res_idx + 1'b1;
            if (res_idx == RW'(M-1)) issued_all <= 1'b1;
          end else if (res_fire) begin
            res_valid_o <= 1'b0;
            res_last_o  <= 1'b0;
            if (res_last_o) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef POLAR_SAT_CNT_EN
  logic res_sat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_sat   <= 1'b0;
      sat_cnt_o <= 16'd0;
    end else begin
      if (issue) res_sat <= k_sat;
      if (cmd_fire) sat_cnt_o <= 16'd0;
      else if (res_fire && res_sat && (sat_cnt_o != 16'hFFFF)) sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_polar_fg_sched.sv
// tb_polar_fg_sched: table-driven checks of polar_fg_sched plus backpressure, priority and reset sequences.
// Revision: 1.0
`default_nettype none

module tb_polar_fg_sched;

  localparam int M = 8;
  localparam int Q = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         llr_valid = 1'b0;
  logic         llr_ready;
  logic [Q-1:0] llr_data = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [M-1:0] cmd_bits = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [Q-1:0] res_data;
  logic         res_last;
  logic         busy;
`ifdef POLAR_SAT_CNT_EN
  logic [15:0]  sat_cnt;
`endif

  always #5 clk = ~clk;

  polar_fg_sched #(.M(M), .QTF_SIZE(Q)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .llr_valid_i (llr_valid),
    .llr_ready_o (llr_ready),
    .llr_data_i  (llr_data),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_bits_i  (cmd_bits),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_last_o  (res_last),
    .busy_o      (busy)
`ifdef POLAR_SAT_CNT_EN
    ,
    .sat_cnt_o   (sat_cnt)
`endif
  );

  typedef struct packed {
    logic            ramp;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [1:0]      op;
    logic [7:0]      bits;
    logic [7:0][7:0] exp;
    logic [15:0]     sat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic ramp, input logic [7:0] a, input logic [7:0] b,
                              input logic [1:0] op, input logic [7:0] bits,
                              input logic [63:0] exp, input logic [15:0] sat);
    vec_t v;
    v.ramp = ramp; v.a = a; v.b = b; v.op = op; v.bits = bits; v.exp = exp; v.sat = sat;
    return v;
  endfunction

  task automatic load_word(input logic [7:0] w);
    int n = 0;
    llr_valid = 1'b1;
    llr_data  = w;
    #1;
    while (!llr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("llr_ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    llr_valid = 1'b0;
  endtask

  task automatic load_vec(input logic ramp, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 2*M; i++)
      load_word(ramp ? 8'(i) : ((i < M) ? a : b));
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] bits);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bits  = bits;
    #1;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check("cmd_ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0][7:0] exp, input string tag);
    res_ready = 1'b1;
    for (int i = 0; i < M; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s valid[%0d]", tag, i), 32'(res_valid), 32'd1);
      check($sformatf("%s data[%0d]", tag, i), 32'(res_data), 32'(exp[i]));
      check($sformatf("%s last[%0d]", tag, i), 32'(res_last), 32'(i == M-1));
    end
    @(posedge clk); #1;
    check({tag, " valid after last"}, 32'(res_valid), 32'd0);
    check({tag, " busy after last"}, 32'(busy), 32'd0);
  endtask

  vec_t v [9];

  initial begin
    int n;
    int last_k;
    logic held;
    logic [7:0] held_data;

    v[0] = mk(1'b1, 8'h00, 8'h00, 2'd0, 8'h00, 64'h0706050403020100, 16'd0);
    v[1] = mk(1'b0, 8'd100, 8'd100, 2'd1, 8'h00, 64'h7F7F7F7F7F7F7F7F, 16'd8);
    v[2] = mk(1'b0, 8'd100, 8'd100, 2'd1, 8'hFF, 64'h0000000000000000, 16'd0);
    v[3] = mk(1'b0, 8'd100, 8'h9C, 2'd1, 8'hFF, 64'h8181818181818181, 16'd8);
    v[4] = mk(1'b0, 8'hFB, 8'h03, 2'd0, 8'h00, 64'hFDFDFDFDFDFDFDFD, 16'd0);
    v[5] = mk(1'b0, 8'h80, 8'hFF, 2'd0, 8'h00, 64'h0101010101010101, 16'd0);
    v[6] = mk(1'b0, 8'hFF, 8'h00, 2'd2, 8'h0F, 64'h0101010100000000, 16'd0);
    v[7] = mk(1'b0, 8'h0A, 8'h03, 2'd1, 8'hAA, 64'hF90DF90DF90DF90D, 16'd0);
    v[8] = mk(1'b0, 8'hFF, 8'h00, 2'd3, 8'h00, 64'h0101010101010101, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", 32'(res_data), 32'd0);
    check("reset res_last", 32'(res_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset llr_ready", 32'(llr_ready), 32'd1);
`ifdef POLAR_SAT_CNT_EN
    check("reset sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 9; r++) begin
      load_vec(v[r].ramp, v[r].a, v[r].b);
      check($sformatf("row%0d cmd_ready when full", r), 32'(cmd_ready), 32'd1);
      send_cmd(v[r].op, v[r].bits);
      drain(v[r].exp, $sformatf("row%0d", r));
`ifdef POLAR_SAT_CNT_EN
      check($sformatf("row%0d sat_cnt", r), 32'(sat_cnt), 32'(v[r].sat));
`endif
    end

    // Command beats a simultaneous load when the vector is full; vector is then reused.
    load_vec(1'b1, 8'h00, 8'h00);
    llr_valid = 1'b1;
    llr_data  = 8'h55;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_bits  = 8'h00;
    #1;
    check("prio llr_ready", 32'(llr_ready), 32'd0);
    check("prio cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("prio busy", 32'(busy), 32'd1);
    check("prio llr_ready in run", 32'(llr_ready), 32'd0);
    llr_valid = 1'b0;
    drain(64'h16141210_0E0C0A08, "reuse G");
    send_cmd(2'd0, 8'h00);
    drain(64'h0706050403020100, "reuse F");

    // Backpressure: ready toggles every cycle.
    res_ready = 1'b0;
    send_cmd(2'd0, 8'h00);
    n = 0; held = 1'b0; held_data = '0; last_k = -1;
    for (int k = 0; k < 40; k++) begin
      if (held) begin
        check("bp hold valid", 32'(res_valid), 32'd1);
        check("bp hold data", 32'(res_data), 32'(held_data));
      end
      res_ready = k[0];
      if (res_valid && res_ready) begin
        check($sformatf("bp data[%0d]", n), 32'(res_data), 32'(n));
        check($sformatf("bp last[%0d]", n), 32'(res_last), 32'(n == M-1));
        n++;
      end
      held      = res_valid && !res_ready;
      held_data = res_data;
      @(posedge clk); #1;
      if (n == M) begin
        last_k = k;
        break;
      end
    end
    check("bp result count", 32'(n), 32'(M));
    check("bp cycles", 32'(last_k + 1), 32'd16);
    check("bp valid after", 32'(res_valid), 32'd0);
    check("bp busy after", 32'(busy), 32'd0);

    // Reset in the middle of a run.
    res_ready = 1'b1;
    send_cmd(2'd0, 8'h00);
    n = 0;
    while (!(res_valid && res_data == 8'd3) && n < 12) begin
      @(posedge clk); #1; n++;
    end
    check("mid-run reached result 3", 32'(n < 12), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset res_valid", 32'(res_valid), 32'd0);
    check("mid reset res_data", 32'(res_data), 32'd0);
    check("mid reset res_last", 32'(res_last), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 2*M-1; i++) load_word(8'(i));
    check("partial reload cmd_ready", 32'(cmd_ready), 32'd0);
    check("partial reload busy", 32'(busy), 32'd1);
    load_word(8'(2*M-1));
    check("full reload cmd_ready", 32'(cmd_ready), 32'd1);
    check("full reload busy", 32'(busy), 32'd0);
    send_cmd(2'd0, 8'h00);
    drain(64'h0706050403020100, "after reset F");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
